// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller and its
// forwarding-select slices.
package hazard_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    MWAIT = 1'b1
  } state_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b11;

  localparam logic [4:0] REG_G0 = 5'd0;

endpackage

// File: rtl/forward_select.sv
// One operand's forwarding mux select. Priority is EX > MEM > WB, and g0 is
// never forwarded because it always reads as zero.
module forward_select
  import hazard_pkg::*;
(
  input  logic [4:0] src,
  input  logic       used,
  input  logic [4:0] ex_rd,
  input  logic       ex_le,
  input  logic [4:0] mem_rd,
  input  logic       mem_le,
  input  logic [4:0] wb_rd,
  input  logic       wb_le,
  output logic [1:0] sel,
  output logic       ex_match
);

  logic live;
  logic mem_match;
  logic wb_match;

  assign live      = used && (src != REG_G0);
  assign ex_match  = live && ex_le  && (src == ex_rd);
  assign mem_match = live && mem_le && (src == mem_rd);
  assign wb_match  = live && wb_le  && (src == wb_rd);

  always_comb begin
    sel = FWD_RF;
    if (ex_match)       sel = FWD_EX;
    else if (mem_match) sel = FWD_MEM;
    else if (wb_match)  sel = FWD_WB;
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline-register enables/clears and operand forwarding for a 5-stage core:
// load-use stalls, data-memory wait freezes and annulled delay-slot squashes.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       ID_rs1,
  input  logic [4:0]       ID_rs2,
  input  logic [4:0]       ID_rd,
  input  logic             ID_rs1_used,
  input  logic             ID_rs2_used,
  input  logic             ID_rd_used,
  input  logic             ID_branch,
  input  logic             ID_annul,
  input  logic [4:0]       EX_RD,
  input  logic             EX_RF_LE,
  input  logic             EX_load,
  input  logic [4:0]       MEM_RD,
  input  logic [4:0]       WB_RD,
  input  logic             MEM_RF_LE,
  input  logic             WB_RF_LE,
  input  logic             dmem_wait,
  output logic [1:0]       FWD_A,
  output logic [1:0]       FWD_B,
  output logic [1:0]       FWD_D,
  output logic             PC_LE,
  output logic             nPC_LE,
  output logic             IF_ID_LE,
  output logic             ID_EX_LE,
  output logic             EX_MEM_LE,
  output logic             IF_ID_clr,
  output logic             ID_EX_clr,
  output logic             MEM_WB_clr,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] squash_cnt
);

  logic [4:0] src      [3];
  logic       used     [3];
  logic [1:0] sel      [3];
  logic       ex_match [3];

  assign src[0]  = ID_rs1;
  assign src[1]  = ID_rs2;
  assign src[2]  = ID_rd;
  assign used[0] = ID_rs1_used;
  assign used[1] = ID_rs2_used;
  assign used[2] = ID_rd_used;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_fwd
      forward_select u_sel (
        .src      (src[gi]),
        .used     (used[gi]),
        .ex_rd    (EX_RD),
        .ex_le    (EX_RF_LE),
        .mem_rd   (MEM_RD),
        .mem_le   (MEM_RF_LE),
        .wb_rd    (WB_RD),
        .wb_le    (WB_RF_LE),
        .sel      (sel[gi]),
        .ex_match (ex_match[gi])
      );
    end
  endgenerate

  assign FWD_A = reset ? FWD_RF : sel[0];
  assign FWD_B = reset ? FWD_RF : sel[1];
  assign FWD_D = reset ? FWD_RF : sel[2];

  logic   lu;
  logic   stall_ev;
  logic   squash_fire;
  state_t state_reg, state_next;
  logic   squash_reg, squash_next;

  assign lu          = EX_load && (ex_match[0] || ex_match[1] || ex_match[2]);
  assign stall_ev    = dmem_wait || lu;
  assign squash_fire = squash_reg && !stall_ev;

  always_comb begin
    state_next  = state_reg;
    squash_next = squash_reg;
    case (state_reg)
      RUN:     if (dmem_wait)  state_next = MWAIT;
      MWAIT:   if (!dmem_wait) state_next = RUN;
      default: state_next = RUN;
    endcase
    // The squashed delay slot is a bubble, so it can never arm a new squash.
    if (!stall_ev) begin
      if (squash_reg)                          squash_next = 1'b0;
      else if (ID_branch && ID_annul && ID_EX_LE) squash_next = 1'b1;
    end
  end

  always_comb begin
    PC_LE      = 1'b1;
    nPC_LE     = 1'b1;
    IF_ID_LE   = 1'b1;
    ID_EX_LE   = 1'b1;
    EX_MEM_LE  = 1'b1;
    IF_ID_clr  = 1'b0;
    ID_EX_clr  = 1'b0;
    MEM_WB_clr = 1'b0;
    if (reset) begin
      PC_LE      = 1'b0;
      nPC_LE     = 1'b0;
      IF_ID_LE   = 1'b0;
      ID_EX_LE   = 1'b0;
      EX_MEM_LE  = 1'b0;
      IF_ID_clr  = 1'b1;
      ID_EX_clr  = 1'b1;
      MEM_WB_clr = 1'b1;
    end else if (dmem_wait) begin
      PC_LE      = 1'b0;
      nPC_LE     = 1'b0;
      IF_ID_LE   = 1'b0;
      ID_EX_LE   = 1'b0;
      EX_MEM_LE  = 1'b0;
      MEM_WB_clr = 1'b1;
    end else if (lu) begin
      // Hold fetch/decode; ID/EX loads a bubble while the load moves on.
      PC_LE     = 1'b0;
      nPC_LE    = 1'b0;
      IF_ID_LE  = 1'b0;
      ID_EX_clr = 1'b1;
    end else if (squash_reg) begin
      ID_EX_clr = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= RUN;
      squash_reg <= 1'b0;
      stall_cnt  <= '0;
      squash_cnt <= '0;
    end else begin
      state_reg  <= state_next;
      squash_reg <= squash_next;
      if (stall_ev && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 1'b1;
      if (squash_fire && (squash_cnt != '1))
        squash_cnt <= squash_cnt + 1'b1;
    end
  end

endmodule
